// File: rtl/imem_loader_if.sv
// Bus bundle between the boot loader and its surroundings: the UART byte
// stream in, the instruction-memory write port out, the ack byte out, and
// the CPU release and status outputs.
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        cpu_run;
    logic        overflow;
    logic [31:0] words_loaded;

    // Host side: supplies received bytes and transmitter readiness.
    modport master (
        output rx_valid, rx_data, tx_ready,
        input  mem_we, mem_waddr, mem_wdata, tx_valid, tx_data,
               cpu_run, overflow, words_loaded
    );

    // Loader side.
    modport slave (
        input  rx_valid, rx_data, tx_ready,
        output mem_we, mem_waddr, mem_wdata, tx_valid, tx_data,
               cpu_run, overflow, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Receives a little-endian word count
// followed by that many little-endian words over the UART byte stream,
// writes the words sequentially to instruction memory, sends one ack byte,
// then releases the CPU. Words beyond the memory depth are consumed but not
// written and flag a sticky overflow.
module imem_loader #(
    parameter int          NUM_WORDS = 1024,
    parameter logic [7:0]  ACK_BYTE  = 8'hAA
) (
    input  logic         clk,
    input  logic         rstn,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_ACK,
        ST_RUN
    } state_t;

    localparam logic [31:0] DEPTH = 32'(NUM_WORDS);

    state_t      state_q;
    logic [1:0]  bcnt_q;
    logic [23:0] asm_q;          // bytes 0..2 of the group being assembled
    logic [31:0] n_q;
    logic [31:0] wptr_q;
    logic        mem_we_q;
    logic [31:0] mem_waddr_q;
    logic [31:0] mem_wdata_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic        cpu_run_q;
    logic        overflow_q;
    logic [31:0] words_loaded_q;

    // The 4th byte completes the word directly from the bus, so the word is
    // usable on the same edge that receives it.
    logic [31:0] word_d;
    logic        byte_last_d;
    assign word_d      = {bus.rx_data, asm_q};
    assign byte_last_d = (bcnt_q == 2'd3);

    // Loader state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= ST_LEN;
            bcnt_q         <= 2'd0;
            asm_q          <= 24'd0;
            n_q            <= 32'd0;
            wptr_q         <= 32'd0;
            mem_we_q       <= 1'b0;
            mem_waddr_q    <= 32'd0;
            mem_wdata_q    <= 32'd0;
            tx_valid_q     <= 1'b0;
            tx_data_q      <= ACK_BYTE;
            cpu_run_q      <= 1'b0;
            overflow_q     <= 1'b0;
            words_loaded_q <= 32'd0;
        end else begin
            case (state_q)
                ST_LEN, ST_DATA: begin
                    if (bus.rx_valid) begin
                        bcnt_q <= bcnt_q + 2'd1;
                        case (bcnt_q)
                            2'd0:    asm_q[7:0]   <= bus.rx_data;
                            2'd1:    asm_q[15:8]  <= bus.rx_data;
                            2'd2:    asm_q[23:16] <= bus.rx_data;
                            default: ;
                        endcase
                        if (byte_last_d) begin
                            if (state_q == ST_LEN) begin
                                n_q    <= word_d;
                                wptr_q <= 32'd0;
                                if (word_d == 32'd0) begin
                                    state_q    <= ST_ACK;
                                    tx_valid_q <= 1'b1;
                                    tx_data_q  <= ACK_BYTE;
                                end else begin
                                    state_q <= ST_DATA;
                                end
                            end else begin
                                // Write strobe is decided here so it is high
                                // during exactly the WRITE cycle.
                                state_q     <= ST_WRITE;
                                mem_waddr_q <= wptr_q;
                                mem_wdata_q <= word_d;
                                mem_we_q    <= (wptr_q < DEPTH);
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    // Bytes arriving here are dropped.
                    mem_we_q <= 1'b0;
                    wptr_q   <= wptr_q + 32'd1;
                    if (mem_we_q) begin
                        words_loaded_q <= words_loaded_q + 32'd1;
                    end else begin
                        overflow_q <= 1'b1;
                    end
                    if (wptr_q + 32'd1 == n_q) begin
                        state_q    <= ST_ACK;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= ACK_BYTE;
                    end else begin
                        state_q <= ST_DATA;
                    end
                end
                ST_ACK: begin
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        cpu_run_q  <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cpu_run_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_LEN;
                end
            endcase
        end
    end

    assign bus.mem_we       = mem_we_q;
    assign bus.mem_waddr    = mem_waddr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.tx_valid     = tx_valid_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.cpu_run      = cpu_run_q;
    assign bus.overflow     = overflow_q;
    assign bus.words_loaded = words_loaded_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time controller for the instruction memory write port. It receives a program image byte-by-byte from the UART receiver and assembles little-endian 32-bit words. It writes them sequentially into instruction memory, acknowledges completion over the UART transmitter, then releases the CPU. Until release, the CPU is held idle, so the write port and fetch never compete.

## Interface

Clocking: one clock `clk`; reset `rstn` is synchronous and active-low.

Parameters:
- `NUM_WORDS`, 1024: instruction memory depth in 32-bit words.
- `ACK_BYTE`, 8'hAA: byte sent to host when loading completes.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  synchronous active-low reset.
- `rx_valid`  in  1  one-cycle pulse, `rx_data` valid; no backpressure.
- `rx_data`  in  8  received byte.
- `mem_we`  out  1  instruction memory write enable.
- `mem_waddr`  out  32  word address of write.
- `mem_wdata`  out  32  word to write.
- `tx_valid`  out  1  ack byte available.
- `tx_ready`  in  1  transmitter accepts byte.
- `tx_data`  out  8  byte to transmit.
- `cpu_run`  out  1  CPU enable; 0 holds PC at 0.
- `overflow`  out  1  sticky: image longer than `NUM_WORDS`.
- `words_loaded`  out  32  count of words actually written.

## Operation

- States:
  - LEN: collect 4-byte word count N, little-endian.
  - DATA: collect N words.
  - WRITE: single write cycle.
  - ACK: offer `ACK_BYTE`.
  - RUN: loading done.
- Byte assembly:
  - 2-bit byte counter `bcnt`.
  - Byte k of each group lands in bits [8k+7:8k].
  - `bcnt` wraps 3→0 on the 4th byte.
- LEN:
  - On the 4th byte, latch N and clear the word pointer `wptr`.
  - N=0 goes to ACK; otherwise DATA.
- DATA:
  - On the 4th byte, go to WRITE with `mem_waddr`=`wptr` and `mem_wdata`=assembled word.
- WRITE:
  - `mem_we`=1 for exactly one cycle only if `wptr` < `NUM_WORDS`.
  - Otherwise `mem_we`=0 and `overflow` is set; the word is still consumed.
  - `wptr`++; `words_loaded`++ only when written.
  - If `wptr`+1 == N, go to ACK; else DATA.
- ACK:
  - `tx_valid`=1 and `tx_data`=`ACK_BYTE`, held until `tx_ready`=1 in the same cycle.
  - Then go to RUN.
- RUN: `cpu_run`=1; all `rx_valid` pulses are ignored.
- Width rules:
  - N is 32-bit unsigned.
  - `wptr` is 32-bit and never wraps in practice.
  - Overflow comparison is unsigned.
- Bytes arriving in WRITE or ACK are dropped, not buffered. The host must wait for the ack.

## Timing

- Reset values:
  - state=LEN, `bcnt`=0, `wptr`=0, N=0.
  - `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0.
  - `tx_valid`=0, `tx_data`=`ACK_BYTE`.
  - `cpu_run`=0, `overflow`=0, `words_loaded`=0.
- Reset asserted mid-operation (any state, including RUN) returns to LEN on the next edge with the values above. Memory contents are untouched.
- Write latency: a 4th-byte `rx_valid` at edge t gives `mem_we`=1 during cycle t+1, with `mem_waddr`/`mem_wdata` stable in that cycle.
- Minimum gap: a 4th byte followed by the next group's 1st byte must be at least 2 cycles apart. The UART byte rate guarantees this.
- ACK:
  - `tx_valid` rises the cycle after the last WRITE, or after the 4th LEN byte when N=0.
  - Handshake on an edge with `tx_valid`&`tx_ready`.
  - `cpu_run` rises the cycle after the handshake.
- `mem_we` and `cpu_run` are never high in the same cycle.
- `overflow` and `words_loaded` are stable from ACK until reset.

## Test plan

1. Reset then idle: all outputs at reset values; 100 cycles with no `rx_valid` → no change.
2. Load 3 words:
   - Stimulus: bytes 03 00 00 00, then 78 56 34 12, EF BE AD DE, 01 00 00 00.
   - Required: writes (0,12345678), (1,DEADBEEF), (2,00000001), one cycle each.
   - Then `tx_valid` with AA; after `tx_ready`, `cpu_run`=1 and `words_loaded`=3.
3. N=0: bytes 00 00 00 00 → no `mem_we`, `tx_valid` the next cycle, `cpu_run` after handshake.
4. Overflow with `NUM_WORDS`=2, N=3:
   - Required: writes to addresses 0 and 1 only; 3rd word consumed with `mem_we`=0.
   - `overflow`=1, `words_loaded`=2, ack still sent.
5. `tx_ready` held low 20 cycles in ACK → `tx_valid` stays 1 and `cpu_run` stays 0; byte pulses during ACK are ignored.
6. `rstn` low for 1 cycle after the 2nd byte of word 1 → state LEN, `bcnt`=0. A fresh 1-word image then loads to address 0 correctly.
